// File: rtl/ifu_npc.sv
`default_nettype none
// ============================================================================
// Module   : ifu_npc
// Brief    : MIPS instruction fetch unit. It holds the PC, fetches over a
//            req/ready handshake and forms the next PC for +4, beq, j/jal and jr.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_npc #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       npc_sel,
    input  logic             zero,
    input  logic [31:0]      ra_data,
    input  logic             stall,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             fetch_err,
    output logic [CNT_W-1:0] issue_cnt
);

    localparam logic [1:0] c_SEL_SEQ = 2'b00;
    localparam logic [1:0] c_SEL_BEQ = 2'b01;
    localparam logic [1:0] c_SEL_J   = 2'b10;

    typedef enum logic [1:0] {
        ST_REQ   = 2'b00,
        ST_ISSUE = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [31:0]      w_pc_nx;
    logic [31:0]      w_instr_nx;
    logic             w_err_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [31:0]      w_npc;
    logic [31:0]      w_branch_off;

    assign pc_plus4     = pc + 32'd4;
    assign imem_addr    = pc;
    assign w_branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};

    always_comb begin
        w_npc = pc_plus4;
        case (npc_sel)
            c_SEL_SEQ: w_npc = pc_plus4;
            c_SEL_BEQ: w_npc = zero ? (pc_plus4 + w_branch_off) : pc_plus4;
            c_SEL_J:   w_npc = {pc_plus4[31:28], instr[25:0], 2'b00};
            default:   w_npc = ra_data;
        endcase
    end

    always_comb begin
        w_state_nx  = r_state;
        w_pc_nx     = pc;
        w_instr_nx  = instr;
        w_err_nx    = fetch_err;
        w_cnt_nx    = issue_cnt;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (r_state)
            ST_REQ: begin
                // Gated by reset so the request drops the instant reset asserts.
                imem_req = ~reset;
                if (imem_ready) begin
                    w_instr_nx = imem_rdata;
                    w_state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    w_pc_nx  = w_npc;
                    w_cnt_nx = issue_cnt + CNT_W'(1);
                    if (w_npc[1:0] != 2'b00) begin
                        w_err_nx   = 1'b1;
                        w_state_nx = ST_HALT;
                    end else begin
                        w_state_nx = ST_REQ;
                    end
                end
            end
            default: begin
                w_state_nx = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_REQ;
            pc        <= PC_RESET;
            instr     <= 32'd0;
            fetch_err <= 1'b0;
            issue_cnt <= '0;
        end else begin
            r_state   <= w_state_nx;
            pc        <= w_pc_nx;
            instr     <= w_instr_nx;
            fetch_err <= w_err_nx;
            issue_cnt <= w_cnt_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifu_npc.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_npc
// Brief    : Self-checking bench for ifu_npc. It runs directed scenarios and then
//            random instruction streams against a transaction-level PC model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_npc;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  npc_sel;
    logic        zero;
    logic [31:0] ra_data;
    logic        stall;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_err;
    logic [31:0] issue_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // Architectural view of the fetch unit: current PC, fetched word, retired count.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_cnt;

    ifu_npc #(.PC_RESET(32'h0000_3000), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .npc_sel(npc_sel), .zero(zero), .ra_data(ra_data),
        .stall(stall), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .imem_req(imem_req), .imem_addr(imem_addr), .instr(instr),
        .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
        .fetch_err(fetch_err), .issue_cnt(issue_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_npc(input logic [1:0] sel, input logic z,
                                              input logic [31:0] ra);
        logic [31:0] seq;
        int          off;
        seq = m_pc + 32'd4;
        off = $signed(m_instr[15:0]) * 4;
        case (sel)
            2'd0:    return seq;
            2'd1:    return z ? seq + 32'(off) : seq;
            2'd2:    return (seq & 32'hF000_0000) + (32'(m_instr[25:0]) * 32'd4);
            default: return ra;
        endcase
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("reset_req_low", 32'(imem_req), 32'd0);
        step();
        reset = 1'b0;
        #1;
        m_pc = 32'h0000_3000; m_instr = 32'd0; m_cnt = 32'd0;
        chk("rst_pc", pc, m_pc);
        chk("rst_pc_plus4", pc_plus4, 32'h0000_3004);
        chk("rst_instr", instr, 32'd0);
        chk("rst_err", 32'(fetch_err), 32'd0);
        chk("rst_cnt", issue_cnt, 32'd0);
    endtask

    // Entered while the unit should be requesting; leaves it presenting the word.
    task automatic fetch_one(input logic [31:0] word, input int wait_cycles);
        chk("req_high", 32'(imem_req), 32'd1);
        chk("req_addr", imem_addr, m_pc);
        chk("req_not_valid", 32'(instr_valid), 32'd0);
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        for (int i = 0; i < wait_cycles; i++) begin
            step();
            chk("wait_req", 32'(imem_req), 32'd1);
            chk("wait_addr", imem_addr, m_pc);
            chk("wait_not_valid", 32'(instr_valid), 32'd0);
        end
        imem_ready = 1'b1;
        imem_rdata = word;
        step();
        imem_ready = $urandom_range(0, 1);
        imem_rdata = $urandom;
        m_instr = word;
        chk("iss_valid", 32'(instr_valid), 32'd1);
        chk("iss_req_low", 32'(imem_req), 32'd0);
        chk("iss_instr", instr, m_instr);
        chk("iss_pc", pc, m_pc);
        chk("iss_pc_plus4", pc_plus4, m_pc + 32'd4);
    endtask

    task automatic issue_one(input logic [1:0] sel, input logic z, input logic [31:0] ra,
                             input int stall_cycles);
        logic [31:0] nxt;
        stall = 1'b1;
        for (int i = 0; i < stall_cycles; i++) begin
            npc_sel = 2'($urandom); zero = 1'($urandom); ra_data = $urandom | 32'd1;
            step();
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_pc", pc, m_pc);
            chk("stall_instr", instr, m_instr);
            chk("stall_cnt", issue_cnt, m_cnt);
        end
        stall = 1'b0; npc_sel = sel; zero = z; ra_data = ra;
        nxt = model_npc(sel, z, ra);
        step();
        stall = 1'($urandom); npc_sel = 2'($urandom); zero = 1'($urandom);
        ra_data = $urandom | 32'd1;
        m_pc  = nxt;
        m_cnt = m_cnt + 32'd1;
        chk("ret_pc", pc, m_pc);
        chk("ret_cnt", issue_cnt, m_cnt);
        chk("ret_err", 32'(fetch_err), 32'((m_pc % 4) != 0));
        chk("ret_valid", 32'(instr_valid), 32'd0);
        chk("ret_req", 32'(imem_req), 32'((m_pc % 4) == 0));
    endtask

    initial begin
        reset = 1'b1; npc_sel = 2'd0; zero = 1'b0; ra_data = 32'd0; stall = 1'b0;
        imem_ready = 1'b0; imem_rdata = 32'd0;
        m_pc = 32'h0000_3000; m_instr = 32'd0; m_cnt = 32'd0;
        #2;
        do_reset();

        // Sequential stream with a zero-wait memory.
        for (int k = 0; k < 3; k++) begin
            fetch_one($urandom, 0);
            issue_one(2'd0, 1'b0, 32'd0, 0);
        end
        chk("seq_cnt3", issue_cnt, 32'd3);
        chk("seq_addr", imem_addr, 32'h0000_300C);

        // Backward beq taken and not taken from 0x3010.
        fetch_one($urandom, 0);
        issue_one(2'd3, 1'b0, 32'h0000_3010, 0);
        fetch_one({16'h1000, 16'hFFFC}, 0);
        issue_one(2'd1, 1'b1, 32'd0, 0);
        chk("beq_taken", imem_addr, 32'h0000_3004);
        fetch_one($urandom, 0);
        issue_one(2'd3, 1'b0, 32'h0000_3010, 0);
        fetch_one({16'h1000, 16'hFFFC}, 0);
        issue_one(2'd1, 1'b0, 32'd0, 0);
        chk("beq_not_taken", imem_addr, 32'h0000_3014);

        // j inside the 0x3000_0000 region.
        fetch_one($urandom, 0);
        issue_one(2'd3, 1'b0, 32'h3000_3000, 0);
        fetch_one({6'b000010, 26'h0000C10}, 0);
        chk("j_pc_plus4", pc_plus4, 32'h3000_3004);
        issue_one(2'd2, 1'b0, 32'd0, 0);
        chk("j_target", imem_addr, 32'h3000_3040);

        // Wrap of sequential PC at the top of the address space.
        fetch_one($urandom, 1);
        issue_one(2'd3, 1'b0, 32'hFFFF_FFFC, 1);
        fetch_one($urandom, 0);
        issue_one(2'd0, 1'b0, 32'd0, 0);
        chk("wrap_pc", pc, 32'd0);

        // Slow memory and downstream stall.
        fetch_one($urandom, 3);
        issue_one(2'd0, 1'b0, 32'd0, 2);

        // Reset while a request is outstanding.
        imem_ready = 1'b0;
        step();
        chk("midreq_req", 32'(imem_req), 32'd1);
        do_reset();
        chk("midreq_addr", imem_addr, 32'h0000_3000);

        // Random instruction stream.
        for (int k = 0; k < 40; k++) begin
            logic [1:0] sel;
            sel = 2'($urandom);
            fetch_one($urandom, $urandom_range(0, 3));
            issue_one(sel, 1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 2));
        end

        // Misaligned jr halts the unit until reset.
        fetch_one($urandom, 0);
        issue_one(2'd3, 1'b0, 32'h0000_3002, 0);
        chk("halt_pc", pc, 32'h0000_3002);
        for (int i = 0; i < 4; i++) begin
            imem_ready = 1'($urandom); stall = 1'($urandom);
            step();
            chk("halt_req", 32'(imem_req), 32'd0);
            chk("halt_valid", 32'(instr_valid), 32'd0);
            chk("halt_err", 32'(fetch_err), 32'd1);
            chk("halt_pc_hold", pc, 32'h0000_3002);
            chk("halt_cnt", issue_cnt, m_cnt);
        end
        do_reset();
        fetch_one($urandom, 0);
        issue_one(2'd0, 1'b0, 32'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
